// File: rtl/ram_sp_param_if.sv
// Access bus for ram_sp_param: request signals from the master,
// read data, valid strobe and busy flag back from the RAM.
interface ram_sp_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;

  modport master (output en, we, addr, din, input dout, dout_valid, busy);
  modport slave  (input en, we, addr, din, output dout, dout_valid, busy);
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with post-reset zero-fill and a read-valid strobe.
// Define RAM_OUT_REG_EN to add a second output register (read latency 2).
module ram_sp_param #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int WRITE_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  ram_sp_param_if.slave  bus
);
  typedef enum logic {CLEAR, IDLE} state_e;

  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic              vld1_q, vld1_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_rng;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] rd_word;

  // Addresses past DEPTH read as zero and are never written.
  assign in_rng  = ({1'b0, bus.addr} < DEPTH_L);
  assign rd_word = in_rng ? mem[bus.addr] : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    dout1_d   = dout1_q;
    vld1_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = bus.addr;
    mem_wd    = bus.din;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_cnt_q[ADDR_W-1:0];
        mem_wd    = '0;
        clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
        if (clr_cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (bus.en) begin
          mem_we = bus.we & in_rng;
          if (!bus.we) begin
            dout1_d = rd_word;
            vld1_d  = 1'b1;
          end else if (WRITE_MODE == 0) begin
            dout1_d = rd_word;
            vld1_d  = 1'b1;
          end else if (WRITE_MODE == 1) begin
            dout1_d = in_rng ? bus.din : '0;
            vld1_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      dout1_q   <= '0;
      vld1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      dout1_q   <= dout1_d;
      vld1_q    <= vld1_d;
    end
  end

  // Array has no reset; the clear sequencer zero-fills it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic              vld2_q, vld2_d;

  always_comb begin
    dout2_d = dout1_q;
    vld2_d  = vld1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout2_q <= '0;
      vld2_q  <= 1'b0;
    end else begin
      dout2_q <= dout2_d;
      vld2_q  <= vld2_d;
    end
  end

  assign bus.dout       = dout2_q;
  assign bus.dout_valid = vld2_q;
`else
  assign bus.dout       = dout1_q;
  assign bus.dout_valid = vld1_q;
`endif

  assign bus.busy = busy_q;
endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench: four RAM instances (READ_FIRST, WRITE_FIRST, NO_CHANGE at
// DEPTH=256, READ_FIRST at DEPTH=200) share one stimulus stream.
module tb_ram_sp_param;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we;
  logic [7:0]  addr;
  logic [15:0] din;
  int          total = 0;
  int          bad   = 0;

  logic [3:0][15:0] dq;
  logic [3:0]       dv, bz;
  logic [3:0][15:0] hd1, hd2;
  logic [3:0]       hv1, hv2;

  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) b0 ();
  ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) b1 ();
  ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) b2 ();
  ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) b3 ();

  assign b0.en = en; assign b0.we = we; assign b0.addr = addr; assign b0.din = din;
  assign b1.en = en; assign b1.we = we; assign b1.addr = addr; assign b1.din = din;
  assign b2.en = en; assign b2.we = we; assign b2.addr = addr; assign b2.din = din;
  assign b3.en = en; assign b3.we = we; assign b3.addr = addr; assign b3.din = din;

  assign dq = {b3.dout, b2.dout, b1.dout, b0.dout};
  assign dv = {b3.dout_valid, b2.dout_valid, b1.dout_valid, b0.dout_valid};
  assign bz = {b3.busy, b2.busy, b1.busy, b0.busy};

  ram_sp_param #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .WRITE_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  ram_sp_param #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .WRITE_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  ram_sp_param #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .WRITE_MODE(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  ram_sp_param #(.DATA_W(16), .DEPTH(200), .ADDR_W(8), .WRITE_MODE(0)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hist_clr();
    hd1 = '0; hd2 = '0; hv1 = '0; hv2 = '0;
  endtask

  // Counts busy cycles per instance from reset release; drives a write during clear.
  task automatic clear_phase();
    int n [4];
    int k;
    for (int i = 0; i < 4; i++) n[i] = 0;
    k = 0;
    while ((|bz) && k < 1000) begin
      for (int i = 0; i < 4; i++) n[i] += int'(bz[i]);
      if (k == 100)
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("clr_vld%0d", i), 32'(dv[i]), 32'd0);
          chk($sformatf("clr_dout%0d", i), 32'(dq[i]), 32'd0);
        end
      en = (k < 150); we = 1'b1; addr = 8'h00; din = 16'hAAAA;
      k++;
      @(negedge clk);
    end
    en = 1'b0; we = 1'b0;
    chk("busy_len0", n[0], 256);
    chk("busy_len1", n[1], 256);
    chk("busy_len2", n[2], 256);
    chk("busy_len3", n[3], 200);
    hist_clr();
  endtask

  // One clock cycle; results show up LAT cycles after the access.
  task automatic cyc(input logic e, input logic w, input logic [7:0] a, input logic [15:0] d,
                     input logic [3:0][15:0] xd, input logic [3:0] xv);
    logic [3:0][15:0] sd;
    logic [3:0]       sv;
    en = e; we = w; addr = a; din = d;
    @(negedge clk);
    hd2 = hd1; hv2 = hv1;
    hd1 = xd;  hv1 = xv;
    sd = (LAT == 1) ? hd1 : hd2;
    sv = (LAT == 1) ? hv1 : hv2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("vld%0d@%h", i, a), 32'(dv[i]), 32'(sv[i]));
      chk($sformatf("dout%0d@%h", i, a), 32'(dq[i]), 32'(sd[i]));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    hist_clr();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_dout%0d", i), 32'(dq[i]), 32'd0);
      chk($sformatf("rst_vld%0d", i), 32'(dv[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'd1);
    end
    rst = 1'b0;
    clear_phase();

    cyc(1, 0, 8'h00, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b1111);
    cyc(1, 0, 8'hFF, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b1111);
    cyc(1, 1, 8'h12, 16'hBEEF, {16'h0, 16'h0, 16'hBEEF, 16'h0},          4'b1011);
    cyc(1, 0, 8'h12, 16'h0,    {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF}, 4'b1111);
    cyc(1, 0, 8'h13, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b1111);
    cyc(0, 0, 8'h00, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b0000);
    cyc(1, 1, 8'h05, 16'h1111, {16'h0, 16'h0, 16'h1111, 16'h0},          4'b1011);
    cyc(1, 1, 8'h05, 16'h2222, {16'h1111, 16'h0, 16'h2222, 16'h1111},    4'b1011);
    cyc(1, 0, 8'h05, 16'h0,    {16'h2222, 16'h2222, 16'h2222, 16'h2222}, 4'b1111);
    cyc(1, 1, 8'h06, 16'h3333, {16'h0, 16'h2222, 16'h3333, 16'h0},       4'b1011);
    cyc(1, 1, 8'hFA, 16'h5555, {16'h0, 16'h2222, 16'h5555, 16'h0},       4'b1011);
    cyc(1, 0, 8'hFA, 16'h0,    {16'h0, 16'h5555, 16'h5555, 16'h5555},    4'b1111);
    cyc(1, 1, 8'hC7, 16'h5555, {16'h0, 16'h5555, 16'h5555, 16'h0},       4'b1011);
    cyc(1, 0, 8'hC7, 16'h0,    {16'h5555, 16'h5555, 16'h5555, 16'h5555}, 4'b1111);
    cyc(0, 0, 8'h00, 16'h0,    {16'h5555, 16'h5555, 16'h5555, 16'h5555}, 4'b0000);
    cyc(0, 0, 8'h00, 16'h0,    {16'h5555, 16'h5555, 16'h5555, 16'h5555}, 4'b0000);

    // Reset lands right after a read is accepted.
    cyc(1, 1, 8'h40, 16'h1234, {16'h0, 16'h5555, 16'h1234, 16'h0},       4'b1011);
    cyc(1, 0, 8'h40, 16'h0,    {16'h1234, 16'h1234, 16'h1234, 16'h1234}, 4'b1111);
    rst = 1'b1; en = 1'b0; we = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_dout%0d", i), 32'(dq[i]), 32'd0);
      chk($sformatf("mid_vld%0d", i), 32'(dv[i]), 32'd0);
      chk($sformatf("mid_busy%0d", i), 32'(bz[i]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_phase();
    cyc(1, 0, 8'h40, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b1111);
    cyc(0, 0, 8'h00, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b0000);
    cyc(0, 0, 8'h00, 16'h0,    {16'h0, 16'h0, 16'h0, 16'h0},             4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
